// File: rtl/eth_pkt_sync_fifo.sv
// Store-and-forward packet FIFO on distributed RAM. Words of a packet become
// visible to the reader only once its EOP word commits without error.
module eth_pkt_sync_fifo #(
    parameter int ADDR_WIDTH       = 9,
    parameter int DATA_WIDTH       = 32,
    parameter int FWFT             = 1,
    parameter int ALMOST_FULL_NUM  = 4,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  wr_eop,
    input  logic                  wr_err,
    output logic                  full,
    output logic                  almost_full,
    output logic                  wr_drop,
    output logic [ADDR_WIDTH:0]   wr_water_level,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_eop,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_water_level,
    output logic [ADDR_WIDTH:0]   pkt_cnt
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] AF_LVL    = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_LVL    = PW'(ALMOST_EMPTY_NUM);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DROP} wr_state_t;

    wr_state_t       state_reg, state_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   cm_ptr_reg, cm_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]   pkt_cnt_reg, pkt_cnt_next;
    logic            wr_drop_reg, wr_drop_next;
    logic            mem_we;
    logic            commit;
    logic            pop;
    logic            pop_eop;
    logic [PW-1:0]   wr_level;
    logic [PW-1:0]   rd_level;
    logic [PW-1:0]   free_lvl;
    logic [DATA_WIDTH:0] rd_word;

    // Top bit of each entry carries the EOP marker.
    logic [DATA_WIDTH:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= {wr_eop, wr_data};
        end
    end

    assign rd_word  = mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
    assign wr_level = wr_ptr_reg - rd_ptr_reg;
    assign rd_level = cm_ptr_reg - rd_ptr_reg;
    assign free_lvl = DEPTH_LVL - wr_level;

    assign full           = (wr_level == DEPTH_LVL);
    assign empty          = (rd_ptr_reg == cm_ptr_reg);
    assign almost_full    = (free_lvl <= AF_LVL);
    assign almost_empty   = (rd_level <= AE_LVL);
    assign wr_water_level = wr_level;
    assign rd_water_level = rd_level;
    assign pkt_cnt        = pkt_cnt_reg;
    assign wr_drop        = wr_drop_reg;

    assign pop     = rd_en & ~empty;
    assign pop_eop = pop & rd_word[DATA_WIDTH];

    always_comb begin
        state_next   = state_reg;
        wr_ptr_next  = wr_ptr_reg;
        cm_ptr_next  = cm_ptr_reg;
        wr_drop_next = 1'b0;
        mem_we       = 1'b0;
        commit       = 1'b0;
        case (state_reg)
            ST_IDLE, ST_ACTIVE: begin
                if (wr_en && !full) begin
                    mem_we      = 1'b1;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    if (wr_eop && !wr_err) begin
                        cm_ptr_next = wr_ptr_reg + 1'b1;
                        commit      = 1'b1;
                        state_next  = ST_IDLE;
                    end else if (wr_eop) begin
                        wr_ptr_next  = cm_ptr_reg;
                        wr_drop_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        state_next = ST_ACTIVE;
                    end
                end else if (wr_en) begin
                    // Overflow: rewind the partial packet and discard the rest.
                    wr_ptr_next = cm_ptr_reg;
                    if (wr_eop) begin
                        wr_drop_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (wr_en && wr_eop) begin
                    wr_drop_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_comb begin
        pkt_cnt_next = pkt_cnt_reg;
        case ({commit, pop_eop})
            2'b10:   pkt_cnt_next = pkt_cnt_reg + 1'b1;
            2'b01:   pkt_cnt_next = pkt_cnt_reg - 1'b1;
            default: pkt_cnt_next = pkt_cnt_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            wr_ptr_reg  <= '0;
            cm_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            pkt_cnt_reg <= '0;
            wr_drop_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            cm_ptr_reg  <= cm_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            pkt_cnt_reg <= pkt_cnt_next;
            wr_drop_reg <= wr_drop_next;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Shadow of the head word so the port holds its value while empty.
            logic [DATA_WIDTH:0] hold_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_reg <= '0;
                end else if (!empty) begin
                    hold_reg <= rd_word;
                end
            end
            assign rd_data = empty ? hold_reg[DATA_WIDTH-1:0] : rd_word[DATA_WIDTH-1:0];
            assign rd_eop  = empty ? hold_reg[DATA_WIDTH] : rd_word[DATA_WIDTH];
        end else begin : g_reg
            logic [DATA_WIDTH:0] rd_q_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q_reg <= '0;
                end else if (pop) begin
                    rd_q_reg <= rd_word;
                end
            end
            assign rd_data = rd_q_reg[DATA_WIDTH-1:0];
            assign rd_eop  = rd_q_reg[DATA_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_eth_pkt_sync_fifo.sv
// Directed bench: a FWFT and a registered-read instance driven by identical stimulus.
module tb_eth_pkt_sync_fifo;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          wr_eop = 1'b0;
    logic          wr_err = 1'b0;
    logic          rd_en = 1'b0;

    logic          full, almost_full, wr_drop, rd_eop, empty, almost_empty;
    logic [AW:0]   wr_water_level, rd_water_level, pkt_cnt;
    logic [DW-1:0] rd_data;

    logic          full0, almost_full0, wr_drop0, rd_eop0, empty0, almost_empty0;
    logic [AW:0]   wr_water_level0, rd_water_level0, pkt_cnt0;
    logic [DW-1:0] rd_data0;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    eth_pkt_sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1),
                        .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(4)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_eop(wr_eop),
        .wr_err(wr_err), .full(full), .almost_full(almost_full), .wr_drop(wr_drop),
        .wr_water_level(wr_water_level), .rd_data(rd_data), .rd_eop(rd_eop),
        .rd_en(rd_en), .empty(empty), .almost_empty(almost_empty),
        .rd_water_level(rd_water_level), .pkt_cnt(pkt_cnt)
    );

    eth_pkt_sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0),
                        .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(4)) dut0 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_eop(wr_eop),
        .wr_err(wr_err), .full(full0), .almost_full(almost_full0), .wr_drop(wr_drop0),
        .wr_water_level(wr_water_level0), .rd_data(rd_data0), .rd_eop(rd_eop0),
        .rd_en(rd_en), .empty(empty0), .almost_empty(almost_empty0),
        .rd_water_level(rd_water_level0), .pkt_cnt(pkt_cnt0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d, input logic eop, input logic err);
        wr_data = d; wr_eop = eop; wr_err = err; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; wr_eop = 1'b0; wr_err = 1'b0;
    endtask

    task automatic pop_word();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
        total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got %0b exp 1", empty); else pass_cnt++;
        total_cnt++; if (almost_empty !== 1'b1) $display("FAIL reset_almost_empty got %0b exp 1", almost_empty); else pass_cnt++;
        total_cnt++; if (full !== 1'b0) $display("FAIL reset_full got %0b exp 0", full); else pass_cnt++;
        total_cnt++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full got %0b exp 0", almost_full); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd0) $display("FAIL reset_pkt_cnt got %0d exp 0", pkt_cnt); else pass_cnt++;
        total_cnt++; if (rd_data0 !== 32'd0) $display("FAIL reset_rd_data0 got %0h exp 0", rd_data0); else pass_cnt++;
        $display("reset: empty=%0b full=%0b pkt_cnt=%0d", empty, full, pkt_cnt);
    endtask

    task automatic test_basic();
        write_word(32'hA, 1'b0, 1'b0);
        total_cnt++; if (empty !== 1'b1) $display("FAIL basic_empty_w1 got %0b exp 1", empty); else pass_cnt++;
        write_word(32'hB, 1'b0, 1'b0);
        total_cnt++; if (empty !== 1'b1) $display("FAIL basic_empty_w2 got %0b exp 1", empty); else pass_cnt++;
        total_cnt++; if (wr_water_level !== 5'd2) $display("FAIL basic_wr_level got %0d exp 2", wr_water_level); else pass_cnt++;
        write_word(32'hC, 1'b1, 1'b0);
        total_cnt++; if (empty !== 1'b0) $display("FAIL basic_empty_commit got %0b exp 0", empty); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd1) $display("FAIL basic_pkt_cnt got %0d exp 1", pkt_cnt); else pass_cnt++;
        total_cnt++; if (rd_water_level !== 5'd3) $display("FAIL basic_rd_level got %0d exp 3", rd_water_level); else pass_cnt++;
        total_cnt++; if (rd_data !== 32'hA || rd_eop !== 1'b0) $display("FAIL basic_rd_A got %0h/%0b exp a/0", rd_data, rd_eop); else pass_cnt++;
        pop_word();
        total_cnt++; if (rd_data !== 32'hB || rd_eop !== 1'b0) $display("FAIL basic_rd_B got %0h/%0b exp b/0", rd_data, rd_eop); else pass_cnt++;
        pop_word();
        total_cnt++; if (rd_data !== 32'hC || rd_eop !== 1'b1) $display("FAIL basic_rd_C got %0h/%0b exp c/1", rd_data, rd_eop); else pass_cnt++;
        pop_word();
        total_cnt++; if (pkt_cnt !== 5'd0) $display("FAIL basic_pkt_cnt_end got %0d exp 0", pkt_cnt); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL basic_empty_end got %0b exp 1", empty); else pass_cnt++;
        $display("basic: 3-word packet written and read, pkt_cnt=%0d", pkt_cnt);
    endtask

    task automatic test_err_drop();
        for (int i = 0; i < 3; i++) write_word(32'h200 + i, 1'b0, 1'b0);
        total_cnt++; if (wr_drop !== 1'b0) $display("FAIL drop_early got %0b exp 0", wr_drop); else pass_cnt++;
        write_word(32'h203, 1'b1, 1'b1);
        total_cnt++; if (wr_drop !== 1'b1) $display("FAIL drop_pulse got %0b exp 1", wr_drop); else pass_cnt++;
        total_cnt++; if (wr_water_level !== 5'd0) $display("FAIL drop_wr_level got %0d exp 0", wr_water_level); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL drop_empty got %0b exp 1", empty); else pass_cnt++;
        tick();
        total_cnt++; if (wr_drop !== 1'b0) $display("FAIL drop_one_cycle got %0b exp 0", wr_drop); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd0) $display("FAIL drop_pkt_cnt got %0d exp 0", pkt_cnt); else pass_cnt++;
        $display("err_drop: errored packet discarded, wr_water_level=%0d", wr_water_level);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) write_word(32'h300 + i, (i == 9), 1'b0);
        total_cnt++; if (rd_water_level !== 5'd10) $display("FAIL ovf_first_commit got %0d exp 10", rd_water_level); else pass_cnt++;
        for (int i = 0; i < 6; i++) write_word(32'h380 + i, 1'b0, 1'b0);
        total_cnt++; if (full !== 1'b1 || wr_water_level !== 5'd16) $display("FAIL ovf_full got %0b/%0d exp 1/16", full, wr_water_level); else pass_cnt++;
        write_word(32'h386, 1'b0, 1'b0);
        total_cnt++; if (wr_water_level !== 5'd10 || full !== 1'b0) $display("FAIL ovf_rewind got %0d/%0b exp 10/0", wr_water_level, full); else pass_cnt++;
        for (int i = 7; i < 19; i++) write_word(32'h380 + i, 1'b0, 1'b0);
        total_cnt++; if (wr_drop !== 1'b0 || wr_water_level !== 5'd10) $display("FAIL ovf_drop_phase got %0b/%0d exp 0/10", wr_drop, wr_water_level); else pass_cnt++;
        write_word(32'h393, 1'b1, 1'b0);
        total_cnt++; if (wr_drop !== 1'b1) $display("FAIL ovf_drop_pulse got %0b exp 1", wr_drop); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd1) $display("FAIL ovf_pkt_cnt got %0d exp 1", pkt_cnt); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if (rd_data !== 32'h300 + i || rd_eop !== (i == 9))
                $display("FAIL ovf_read_%0d got %0h/%0b exp %0h/%0b", i, rd_data, rd_eop, 32'h300 + i, (i == 9));
            else pass_cnt++;
            pop_word();
        end
        total_cnt++; if (empty !== 1'b1 || pkt_cnt !== 5'd0) $display("FAIL ovf_end got %0b/%0d exp 1/0", empty, pkt_cnt); else pass_cnt++;
        $display("overflow: oversize packet dropped, first packet read intact");
    endtask

    task automatic test_almost();
        for (int i = 0; i < 11; i++) write_word(32'h400 + i, (i % 4 == 3), 1'b0);
        total_cnt++; if (almost_full !== 1'b0) $display("FAIL almost_full_11 got %0b exp 0", almost_full); else pass_cnt++;
        write_word(32'h40B, 1'b1, 1'b0);
        total_cnt++; if (almost_full !== 1'b1) $display("FAIL almost_full_12 got %0b exp 1", almost_full); else pass_cnt++;
        total_cnt++; if (almost_empty !== 1'b0) $display("FAIL almost_empty_12 got %0b exp 0", almost_empty); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd3) $display("FAIL almost_pkt_cnt got %0d exp 3", pkt_cnt); else pass_cnt++;
        for (int i = 0; i < 7; i++) pop_word();
        total_cnt++; if (almost_empty !== 1'b0 || rd_water_level !== 5'd5) $display("FAIL almost_empty_5 got %0b/%0d exp 0/5", almost_empty, rd_water_level); else pass_cnt++;
        pop_word();
        total_cnt++; if (almost_empty !== 1'b1 || rd_water_level !== 5'd4) $display("FAIL almost_empty_4 got %0b/%0d exp 1/4", almost_empty, rd_water_level); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd1) $display("FAIL almost_pkt_cnt_drain got %0d exp 1", pkt_cnt); else pass_cnt++;
        for (int i = 0; i < 4; i++) pop_word();
        total_cnt++; if (empty !== 1'b1) $display("FAIL almost_drained got %0b exp 1", empty); else pass_cnt++;
        $display("almost: thresholds at 12 and 4 checked");
    endtask

    task automatic test_back_to_back();
        write_word(32'h501, 1'b1, 1'b0);
        wr_data = 32'h502; wr_eop = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; wr_eop = 1'b0; rd_en = 1'b0;
        total_cnt++; if (pkt_cnt !== 5'd1) $display("FAIL b2b_pkt_cnt got %0d exp 1", pkt_cnt); else pass_cnt++;
        total_cnt++; if (rd_data !== 32'h502 || rd_water_level !== 5'd1) $display("FAIL b2b_head got %0h/%0d exp 502/1", rd_data, rd_water_level); else pass_cnt++;
        pop_word();
        total_cnt++; if (pkt_cnt !== 5'd0 || empty !== 1'b1) $display("FAIL b2b_end got %0d/%0b exp 0/1", pkt_cnt, empty); else pass_cnt++;
        $display("back_to_back: commit with EOP pop kept pkt_cnt");
    endtask

    task automatic test_registered_read();
        write_word(32'h600, 1'b0, 1'b0);
        write_word(32'h601, 1'b1, 1'b0);
        total_cnt++; if (rd_data0 !== 32'h502) $display("FAIL reg_held got %0h exp 502", rd_data0); else pass_cnt++;
        pop_word();
        total_cnt++; if (rd_data0 !== 32'h600 || rd_eop0 !== 1'b0) $display("FAIL reg_first got %0h/%0b exp 600/0", rd_data0, rd_eop0); else pass_cnt++;
        pop_word();
        total_cnt++; if (rd_data0 !== 32'h601 || rd_eop0 !== 1'b1) $display("FAIL reg_second got %0h/%0b exp 601/1", rd_data0, rd_eop0); else pass_cnt++;
        pop_word();
        total_cnt++; if (rd_data0 !== 32'h601 || rd_water_level0 !== 5'd0 || wr_water_level0 !== 5'd0) $display("FAIL reg_empty_pop got %0h/%0d/%0d exp 601/0/0", rd_data0, rd_water_level0, wr_water_level0); else pass_cnt++;
        total_cnt++; if (rd_data !== 32'h601) $display("FAIL fwft_held got %0h exp 601", rd_data); else pass_cnt++;
        $display("registered_read: 1-cycle latency and hold on empty");
    endtask

    task automatic test_reset_mid();
        write_word(32'h700, 1'b0, 1'b0);
        write_word(32'h701, 1'b1, 1'b0);
        write_word(32'h702, 1'b0, 1'b0);
        write_word(32'h703, 1'b1, 1'b0);
        write_word(32'h704, 1'b0, 1'b0);
        total_cnt++; if (pkt_cnt !== 5'd2) $display("FAIL rstmid_pre got %0d exp 2", pkt_cnt); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) $display("FAIL rstmid_flags got e%0b ae%0b f%0b af%0b exp 1100", empty, almost_empty, full, almost_full); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd0 || wr_water_level !== 5'd0 || rd_water_level !== 5'd0) $display("FAIL rstmid_levels got %0d/%0d/%0d exp 0/0/0", pkt_cnt, wr_water_level, rd_water_level); else pass_cnt++;
        total_cnt++; if (rd_data !== 32'd0 || rd_eop !== 1'b0 || rd_data0 !== 32'd0 || rd_eop0 !== 1'b0) $display("FAIL rstmid_rd got %0h/%0b %0h/%0b exp 0", rd_data, rd_eop, rd_data0, rd_eop0); else pass_cnt++;
        tick();
        rst = 1'b0;
        tick();
        write_word(32'h800, 1'b0, 1'b0);
        write_word(32'h801, 1'b1, 1'b0);
        total_cnt++; if (rd_water_level !== 5'd2 || pkt_cnt !== 5'd1) $display("FAIL rstmid_after got %0d/%0d exp 2/1", rd_water_level, pkt_cnt); else pass_cnt++;
        total_cnt++; if (rd_data !== 32'h800) $display("FAIL rstmid_rd0 got %0h exp 800", rd_data); else pass_cnt++;
        pop_word();
        total_cnt++; if (rd_data !== 32'h801 || rd_eop !== 1'b1 || rd_data0 !== 32'h800) $display("FAIL rstmid_rd1 got %0h/%0b/%0h exp 801/1/800", rd_data, rd_eop, rd_data0); else pass_cnt++;
        $display("reset_mid: async reset cleared state, new packet ok");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err_drop();
        test_overflow();
        test_almost();
        test_back_to_back();
        test_registered_read();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/eth_pkt_sync_fifo.md
# eth_pkt_sync_fifo

Single-clock, store-and-forward packet FIFO on distributed RAM for the Ethernet datapath. Successor to the generic distributed FIFO: adds packet framing (per-word EOP), write-side commit/discard so the reader only ever sees complete good packets, overflow truncation handling, a committed-packet counter and a selectable first-word-fall-through read port. Sits between the MAC receive path and the packet consumer, both on the same clock.

## Interface
- ADDR_WIDTH, 9, depth = 2^ADDR_WIDTH words, legal 4..10
- DATA_WIDTH, 32, payload width, legal 1..256
- FWFT, 1, 1 = first-word-fall-through read, 0 = registered read with 1-cycle latency
- ALMOST_FULL_NUM, 4, almost_full when free words <= this value
- ALMOST_EMPTY_NUM, 4, almost_empty when committed words <= this value
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- wr_data  in  DATA_WIDTH  write payload
- wr_en  in  1  write strobe
- wr_eop  in  1  word is last of packet
- wr_err  in  1  sampled with wr_eop; 1 = discard packet
- full  out  1  no free word
- almost_full  out  1  see ALMOST_FULL_NUM
- wr_drop  out  1  one-cycle pulse: a packet was discarded
- wr_water_level  out  ADDR_WIDTH+1  words held incl. uncommitted
- rd_data  out  DATA_WIDTH  read payload
- rd_eop  out  1  rd_data is last word of packet
- rd_en  in  1  read/pop strobe
- empty  out  1  no committed word available
- almost_empty  out  1  see ALMOST_EMPTY_NUM
- rd_water_level  out  ADDR_WIDTH+1  committed words held
- pkt_cnt  out  ADDR_WIDTH+1  complete packets held

## Operation
- Storage: 2^ADDR_WIDTH x (DATA_WIDTH+1) distributed RAM, extra bit = EOP. Pointers wr_ptr (speculative), cm_ptr (commit), rd_ptr, each ADDR_WIDTH+1 bits, wrap modulo 2^(ADDR_WIDTH+1).
- full = (wr_ptr - rd_ptr) == 2^ADDR_WIDTH; empty = (rd_ptr == cm_ptr). wr_water_level = wr_ptr - rd_ptr; rd_water_level = cm_ptr - rd_ptr.
- Write FSM, states IDLE / ACTIVE / DROP:
  - IDLE/ACTIVE, wr_en & ~full: store word, wr_ptr+1. If wr_eop & ~wr_err: cm_ptr <= wr_ptr+1, pkt_cnt+1, -> IDLE. If wr_eop & wr_err: wr_ptr <= cm_ptr, wr_drop=1, -> IDLE. Else -> ACTIVE.
  - IDLE/ACTIVE, wr_en & full: wr_ptr <= cm_ptr (rewind partial packet). If wr_eop: wr_drop=1, stay/go IDLE; else -> DROP.
  - DROP: nothing stored; wr_en & wr_eop -> wr_drop=1, -> IDLE.
- A single packet larger than depth is therefore always dropped, never deadlocks.
- Read: rd_en & ~empty pops rd_ptr+1; rd_en while empty ignored. FWFT=1: rd_data/rd_eop show word at rd_ptr whenever ~empty (undefined-but-stable, held at last value, when empty). FWFT=0: rd_data/rd_eop registered, updated on the edge of a valid pop, held otherwise.
- pkt_cnt decrements when a popped word has EOP=1; simultaneous commit and EOP pop leaves pkt_cnt unchanged.
- almost_full = (2^ADDR_WIDTH - wr_water_level) <= ALMOST_FULL_NUM; almost_empty = rd_water_level <= ALMOST_EMPTY_NUM.

## Timing
- Reset (async assert, sync release on clk): all pointers 0, FSM IDLE, empty=1, almost_empty=1, full=0, almost_full=0, levels 0, pkt_cnt 0, wr_drop 0, rd_data 0, rd_eop 0.
- All flags/levels derive from registered state: they reflect an edge's effect in the following cycle, no further latency.
- Store-and-forward: EOP word accepted on edge N -> empty=0 in cycle N+1. Non-EOP words never clear empty.
- FWFT=0: data for a pop on edge N valid in cycle N+1.
- Simultaneous write and pop in same cycle both take effect; pop frees space for writes only from the next cycle (full is sampled pre-edge).
- wr_drop high exactly one cycle per discarded packet.

## Test plan
- ADDR_WIDTH=4, FWFT=1: write 3-word packet A,B,C(eop) -> empty=1 for cycles 1-3, empty=0 in cycle 4, pkt_cnt=1, rd_water_level=3; pop 3 -> rd_data A,B,C with rd_eop on C, pkt_cnt=0, empty=1.
- Write 4 words with wr_err=1 on EOP -> wr_drop single pulse, wr_water_level returns 0, empty stays 1, pkt_cnt 0.
- Commit 10-word packet, then write 20-word packet without reading -> overflow at word 7, wr_water_level back to 10, wr_drop on word 20, first packet reads out intact, pkt_cnt=1.
- Fill to 12 committed words -> almost_full=1 at level 12, almost_empty=0; drain to 4 -> almost_empty=1.
- FWFT=0: pop on edge N -> rd_data valid cycle N+1; rd_en while empty -> rd_data held, pointers unchanged.
- Assert rst mid-packet with 2 packets stored -> all outputs to reset values immediately; next packet writes and reads normally from address 0.
